enemy_ai_scheduler: RTL and testbench
=====================================

Name: enemy_ai_scheduler

Overview:
Deterministic-plus-pseudorandom action scheduler for the enemy character. It replaces the raw random bit streams on the enemy's movement, attack and defend inputs with an FSM. The FSM re-decides at a fixed tick rate from the player/enemy/bullet positions and an internal LFSR. It sits in the game controller between the game state and the Enemy/BadBullet instances, and is active only while in the play state.

Parameters:
TICK_DIV, 64, cycles between decisions (power of 2, >=4)
NEAR_DX, 160, |dx| below this makes the enemy back off
FAR_DX, 320, |dx| above this makes the enemy chase
DANGER_DX, 96, player-bullet horizontal distance that triggers evasion
ATK_COOLDOWN, 256, cycles after an attack pulse before the next attack is allowed
LFSR_SEED, 8'hA5, LFSR reset value (nonzero)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_enable  in  1  high while the game is in the play state
i_player_x  in  11 signed  player x
i_enemy_x  in  11 signed  enemy x
i_goodbullet_x  in  11 signed  player bullet x
i_goodbullet_isE  in  1  player bullet exists
i_badbullet_isE  in  1  enemy bullet exists
o_right  out  1  move right (level)
o_left  out  1  move left (level)
o_jump  out  1  jump (1-cycle pulse)
o_squat  out  1  squat (level)
o_defend  out  1  shield (level)
o_attack  out  1  fire (1-cycle pulse)
o_state  out  3  current FSM state (debug/HUD)

Behaviour:
- Reset: clk is the clock; rst_n is the reset, asynchronous, active-low. All outputs 0, state IDLE, tick counter 0, cooldown 0, LFSR=LFSR_SEED.
- States and encodings: IDLE=0, CHASE=1, KEEP=2, ATTACK=3, DEFEND=4, EVADE=5. Codes 6 and 7 are unreachable and return to IDLE.
- i_enable low: next state IDLE; tick counter and cooldown cleared; LFSR holds; all outputs 0 from the next cycle.
- Tick counter: runs 0..TICK_DIV-1 while enabled, then wraps. A decision occurs in the cycle when tick==TICK_DIV-1, and the new state is registered on that edge.
- Leaving IDLE: the first decision occurs TICK_DIV cycles after i_enable rises.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances once per decision, after the current value has been used.
- Arithmetic: dx = i_player_x - i_enemy_x and bx = i_goodbullet_x - i_enemy_x, both 12-bit signed, so no overflow. Magnitudes are unsigned 11 bits.
- Decision priority, evaluated in order:
  1. i_goodbullet_isE and |bx| < DANGER_DX: go to DEFEND if lfsr[0] else EVADE.
  2. |dx| > FAR_DX: go to CHASE.
  3. |dx| < NEAR_DX: go to KEEP.
  4. cooldown==0: go to ATTACK.
  5. Otherwise go to CHASE.
- Every state persists until the next decision.
- CHASE: o_right=(dx>0), o_left=(dx<0). dx==0 gives no movement.
- KEEP: direction opposite to CHASE. dx==0 moves left.
- ATTACK: in the first cycle in state, o_attack=1 only if !i_badbullet_isE; cooldown then loads ATK_COOLDOWN. If suppressed, no pulse and no cooldown load. No movement.
- DEFEND: o_defend=1 for the whole state duration.
- EVADE: a lfsr[1] snapshot is taken at decision. If 1, o_jump pulses in the first cycle in state. If 0, o_squat=1 for the whole state duration.
- Cooldown: decrements each enabled cycle while nonzero and saturates at 0. Loading takes priority over decrementing.
- Invariants:
  - o_right and o_left are never both 1.
  - o_attack and o_defend are never both 1.
  - Pulses are exactly 1 cycle.
  - All outputs are registered.
- Reset mid-state: immediate return to reset values; no pending pulse survives.

Test Plan:
- Reset, then i_enable=1, player_x=600, enemy_x=100, no bullets -> o_state stays 0 for 64 cycles, then 1 with o_right=1, o_left=0.
- player_x=300, enemy_x=100 (dx=200), cooldown 0, badbullet absent -> ATTACK, o_attack high for exactly 1 cycle, no new attack pulse for 256 cycles; next decision with dx=200 and cooldown>0 -> CHASE.
- Same as previous case but i_badbullet_isE=1 -> ATTACK state with no o_attack pulse; next decision re-enters ATTACK.
- goodbullet_isE=1, goodbullet_x=enemy_x+50, LFSR_SEED=8'hA5 (bit0=1) -> DEFEND with o_defend high for 64 cycles; with seed 8'hA4 -> EVADE, where bit1=0 gives o_squat level for 64 cycles.
- player_x=enemy_x+40 -> KEEP with o_left=1; player_x=enemy_x-40 -> o_right=1; player_x=enemy_x -> o_left=1.
- i_enable dropped mid-DEFEND -> next cycle all outputs 0, o_state=0; re-enable -> first decision 64 cycles later; rst_n pulsed mid-ATTACK -> outputs 0 asynchronously.

Source files
------------

// File: rtl/enemy_ai_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_ai_scheduler
//  Description : Tick-paced enemy action FSM driven by player/enemy/bullet
//                positions and an 8-bit LFSR; all outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_ai_scheduler #(
    parameter int          TICK_DIV     = 64,
    parameter int          NEAR_DX      = 160,
    parameter int          FAR_DX       = 320,
    parameter int          DANGER_DX    = 96,
    parameter int          ATK_COOLDOWN = 256,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic signed [10:0] i_player_x,
    input  logic signed [10:0] i_enemy_x,
    input  logic signed [10:0] i_goodbullet_x,
    input  logic               i_goodbullet_isE,
    input  logic               i_badbullet_isE,
    output logic               o_right,
    output logic               o_left,
    output logic               o_jump,
    output logic               o_squat,
    output logic               o_defend,
    output logic               o_attack,
    output logic [2:0]         o_state
);

    localparam int              c_TICK_W  = $clog2(TICK_DIV);
    localparam int              c_CD_W    = $clog2(ATK_COOLDOWN + 1);
    localparam logic [10:0]     c_NEAR    = 11'(NEAR_DX);
    localparam logic [10:0]     c_FAR     = 11'(FAR_DX);
    localparam logic [10:0]     c_DANGER  = 11'(DANGER_DX);
    localparam logic [c_CD_W-1:0] c_CD_LOAD = c_CD_W'(ATK_COOLDOWN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHASE  = 3'd1,
        S_KEEP   = 3'd2,
        S_ATTACK = 3'd3,
        S_DEFEND = 3'd4,
        S_EVADE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_CD_W-1:0]   r_cooldown;
    logic [7:0]          r_lfsr;
    logic                r_evade_jump;

    logic                r_right, r_left, r_jump, r_squat, r_defend, r_attack;
    logic                w_right, w_left, w_jump, w_squat, w_defend, w_attack;

    logic signed [11:0]  w_dx, w_bx;
    logic [10:0]         w_adx, w_abx;
    logic                w_decide, w_danger, w_load_cd, w_lfsr_fb;

    // Sign-extend to 12 bits so the difference of two 11-bit values cannot overflow
    assign w_dx  = {i_player_x[10], i_player_x} - {i_enemy_x[10], i_enemy_x};
    assign w_bx  = {i_goodbullet_x[10], i_goodbullet_x} - {i_enemy_x[10], i_enemy_x};
    assign w_adx = w_dx[11] ? (~w_dx[10:0] + 11'd1) : w_dx[10:0];
    assign w_abx = w_bx[11] ? (~w_bx[10:0] + 11'd1) : w_bx[10:0];

    // TICK_DIV is a power of two, so the terminal count is all ones
    assign w_decide  = i_enable && (&r_tick);
    assign w_danger  = i_goodbullet_isE && (w_abx < c_DANGER);
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_load_cd = w_attack;

    always_comb begin
        w_state_nxt = r_state;
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
        end else if (w_decide) begin
            if (w_danger)                w_state_nxt = r_lfsr[0] ? S_DEFEND : S_EVADE;
            else if (w_adx > c_FAR)      w_state_nxt = S_CHASE;
            else if (w_adx < c_NEAR)     w_state_nxt = S_KEEP;
            else if (r_cooldown == '0)   w_state_nxt = S_ATTACK;
            else                         w_state_nxt = S_CHASE;
        end else begin
            case (r_state)
                S_IDLE, S_CHASE, S_KEEP, S_ATTACK, S_DEFEND, S_EVADE: w_state_nxt = r_state;
                default:                                              w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are a function of the state being entered, registered alongside it
    always_comb begin
        w_right  = 1'b0;
        w_left   = 1'b0;
        w_jump   = 1'b0;
        w_squat  = 1'b0;
        w_defend = 1'b0;
        w_attack = 1'b0;
        case (w_state_nxt)
            S_CHASE: begin
                w_right = !w_dx[11] && (w_dx != 12'sd0);
                w_left  = w_dx[11];
            end
            S_KEEP: begin
                w_right = w_dx[11];
                w_left  = !w_dx[11];
            end
            S_ATTACK: w_attack = w_decide && !i_badbullet_isE;
            S_DEFEND: w_defend = 1'b1;
            S_EVADE: begin
                if (w_decide) begin
                    w_jump  = r_lfsr[1];
                    w_squat = !r_lfsr[1];
                end else begin
                    w_squat = !r_evade_jump;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_cooldown   <= '0;
            r_lfsr       <= LFSR_SEED;
            r_evade_jump <= 1'b0;
            r_right      <= 1'b0;
            r_left       <= 1'b0;
            r_jump       <= 1'b0;
            r_squat      <= 1'b0;
            r_defend     <= 1'b0;
            r_attack     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_right  <= w_right;
            r_left   <= w_left;
            r_jump   <= w_jump;
            r_squat  <= w_squat;
            r_defend <= w_defend;
            r_attack <= w_attack;
            if (!i_enable) begin
                r_tick     <= '0;
                r_cooldown <= '0;
            end else begin
                r_tick <= r_tick + c_TICK_W'(1);
                if (w_load_cd)
                    r_cooldown <= c_CD_LOAD;
                else if (r_cooldown != '0)
                    r_cooldown <= r_cooldown - c_CD_W'(1);
            end
            if (w_decide) begin
                r_lfsr       <= {r_lfsr[6:0], w_lfsr_fb};
                r_evade_jump <= r_lfsr[1];
            end
        end
    end

    assign o_right  = r_right;
    assign o_left   = r_left;
    assign o_jump   = r_jump;
    assign o_squat  = r_squat;
    assign o_defend = r_defend;
    assign o_attack = r_attack;
    assign o_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_enemy_ai_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enemy_ai_scheduler
//  Description : Directed vector table plus multi-cycle sequences for the
//                enemy AI scheduler (two instances: seeds A5 and A4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_ai_scheduler;

    logic clk = 1'b0;
    logic rst_n, en;
    logic signed [10:0] px, ex, gbx;
    logic gbe, bbe;

    logic right1, left1, jump1, squat1, defend1, attack1;
    logic right2, left2, jump2, squat2, defend2, attack2;
    logic [2:0] st1, st2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    enemy_ai_scheduler #(.LFSR_SEED(8'hA5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_enable(en),
        .i_player_x(px), .i_enemy_x(ex), .i_goodbullet_x(gbx),
        .i_goodbullet_isE(gbe), .i_badbullet_isE(bbe),
        .o_right(right1), .o_left(left1), .o_jump(jump1), .o_squat(squat1),
        .o_defend(defend1), .o_attack(attack1), .o_state(st1)
    );

    enemy_ai_scheduler #(.LFSR_SEED(8'hA4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_enable(en),
        .i_player_x(px), .i_enemy_x(ex), .i_goodbullet_x(gbx),
        .i_goodbullet_isE(gbe), .i_badbullet_isE(bbe),
        .o_right(right2), .o_left(left2), .o_jump(jump2), .o_squat(squat2),
        .o_defend(defend2), .o_attack(attack2), .o_state(st2)
    );

    typedef struct {
        int px; int ex; int gbx; bit gbe; bit bbe;
        int st1; int st2; bit r; bit l; bit a; bit d; bit sq2;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic set_in(input int p, input int e, input int g, input bit ge, input bit be);
        logic [31:0] t;
        t = p;  px  = t[10:0];
        t = e;  ex  = t[10:0];
        t = g;  gbx = t[10:0];
        gbe = ge;
        bbe = be;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((right1 && left1) || (attack1 && defend1) || (right2 && left2) || (attack2 && defend2)) begin
                errors++;
                $display("FAIL invariant: r1=%b l1=%b a1=%b d1=%b r2=%b l2=%b a2=%b d2=%b",
                         right1, left1, attack1, defend1, right2, left2, attack2, defend2);
            end
        end
    end

    initial begin
        int pulses, cnt_def, cnt_sq;
        //           px    ex    gbx  gbe bbe st1 st2 r  l  a  d  sq2
        vecs[0]  = '{ 600,  100,   0, 0, 0,  1,  1, 1, 0, 0, 0, 0};
        vecs[1]  = '{ 140,  100,   0, 0, 0,  2,  2, 0, 1, 0, 0, 0};
        vecs[2]  = '{  60,  100,   0, 0, 0,  2,  2, 1, 0, 0, 0, 0};
        vecs[3]  = '{ 100,  100,   0, 0, 0,  2,  2, 0, 1, 0, 0, 0};
        vecs[4]  = '{-500,  100,   0, 0, 0,  1,  1, 0, 1, 0, 0, 0};
        vecs[5]  = '{ 300,  100,   0, 0, 0,  3,  3, 0, 0, 1, 0, 0};
        vecs[6]  = '{ 300,  100,   0, 0, 1,  3,  3, 0, 0, 0, 0, 0};
        vecs[7]  = '{ 260,  100,   0, 0, 0,  3,  3, 0, 0, 1, 0, 0};
        vecs[8]  = '{ 420,  100,   0, 0, 0,  3,  3, 0, 0, 1, 0, 0};
        vecs[9]  = '{ 259,  100,   0, 0, 0,  2,  2, 0, 1, 0, 0, 0};
        vecs[10] = '{ 421,  100,   0, 0, 0,  1,  1, 1, 0, 0, 0, 0};
        vecs[11] = '{ 600,  100, 150, 1, 0,  4,  5, 0, 0, 0, 1, 1};
        vecs[12] = '{ 600,  100, 196, 1, 0,  1,  1, 1, 0, 0, 0, 0};
        vecs[13] = '{ 600,  100,   5, 1, 0,  4,  5, 0, 0, 0, 1, 1};
        vecs[14] = '{ 600,  100, 150, 0, 0,  1,  1, 1, 0, 0, 0, 0};
        vecs[15] = '{-600, -300,   0, 0, 0,  3,  3, 0, 0, 1, 0, 0};
        vecs[16] = '{1023,-1024,   0, 0, 0,  1,  1, 1, 0, 0, 0, 0};
        vecs[17] = '{-1024,1023,   0, 0, 0,  1,  1, 0, 1, 0, 0, 0};

        set_in(0, 0, 0, 0, 0);
        do_reset();
        chk("reset_state", 32'(st1), 0);
        chk("reset_outs", {right1, left1, jump1, squat1, defend1, attack1}, 0);

        foreach (vecs[i]) begin
            do_reset();
            set_in(vecs[i].px, vecs[i].ex, vecs[i].gbx, vecs[i].gbe, vecs[i].bbe);
            en = 1'b1;
            step(63);
            chk($sformatf("v%0d_pre_state", i), 32'(st1), 0);
            step(1);
            chk($sformatf("v%0d_state1", i), 32'(st1), vecs[i].st1);
            chk($sformatf("v%0d_right", i), 32'(right1), 32'(vecs[i].r));
            chk($sformatf("v%0d_left", i), 32'(left1), 32'(vecs[i].l));
            chk($sformatf("v%0d_attack", i), 32'(attack1), 32'(vecs[i].a));
            chk($sformatf("v%0d_defend", i), 32'(defend1), 32'(vecs[i].d));
            chk($sformatf("v%0d_state2", i), 32'(st2), vecs[i].st2);
            chk($sformatf("v%0d_squat2", i), 32'(squat2), 32'(vecs[i].sq2));
        end

        // Attack, then cooldown keeps further decisions in CHASE until it drains
        do_reset();
        set_in(300, 100, 0, 0, 0);
        en = 1'b1;
        step(64);
        chk("cd_first_state", 32'(st1), 3);
        chk("cd_first_pulse", 32'(attack1), 1);
        pulses = 0;
        for (int k = 0; k < 319; k++) begin
            step(1);
            if (attack1) pulses++;
            if (k == 63) chk("cd_next_chase", 32'(st1), 1);
        end
        chk("cd_no_pulse", 32'(pulses), 0);
        chk("cd_still_chase", 32'(st1), 1);
        step(1);
        chk("cd_reattack_state", 32'(st1), 3);
        chk("cd_reattack_pulse", 32'(attack1), 1);
        step(1);
        chk("cd_pulse_width", 32'(attack1), 0);

        // Enemy bullet present suppresses the pulse and the cooldown load
        do_reset();
        set_in(300, 100, 0, 0, 1);
        en = 1'b1;
        step(64);
        chk("bb_state", 32'(st1), 3);
        chk("bb_no_pulse", 32'(attack1), 0);
        pulses = 0;
        for (int k = 0; k < 64; k++) begin
            step(1);
            if (attack1) pulses++;
        end
        chk("bb_pulses", 32'(pulses), 0);
        chk("bb_reenter", 32'(st1), 3);

        // Danger: seed A5 defends, seed A4 squats; next LFSR value 4A gives a jump
        do_reset();
        set_in(600, 100, 150, 1, 0);
        en = 1'b1;
        step(64);
        chk("dg_state1", 32'(st1), 4);
        chk("dg_state2", 32'(st2), 5);
        chk("dg_jump2", 32'(jump2), 0);
        cnt_def = defend1 ? 1 : 0;
        cnt_sq  = squat2 ? 1 : 0;
        for (int k = 0; k < 63; k++) begin
            step(1);
            if (defend1) cnt_def++;
            if (squat2)  cnt_sq++;
        end
        chk("dg_defend_len", 32'(cnt_def), 64);
        chk("dg_squat_len", 32'(cnt_sq), 64);
        step(1);
        chk("dg2_state1", 32'(st1), 5);
        chk("dg2_jump1", 32'(jump1), 1);
        chk("dg2_squat1", 32'(squat1), 0);
        chk("dg2_defend1", 32'(defend1), 0);
        chk("dg2_squat2", 32'(squat2), 1);
        step(1);
        chk("dg2_jump_width", 32'(jump1), 0);
        chk("dg2_state_hold", 32'(st1), 5);

        // Enable dropped mid-DEFEND; LFSR holds, so re-entry decides EVADE+jump
        do_reset();
        set_in(600, 100, 150, 1, 0);
        en = 1'b1;
        step(74);
        chk("en_defend", 32'(st1), 4);
        en = 1'b0;
        step(1);
        chk("en_off_state", 32'(st1), 0);
        chk("en_off_outs", {right1, left1, jump1, squat1, defend1, attack1}, 0);
        step(5);
        en = 1'b1;
        step(63);
        chk("en_re_pre", 32'(st1), 0);
        step(1);
        chk("en_re_state1", 32'(st1), 5);
        chk("en_re_jump1", 32'(jump1), 1);
        chk("en_re_state2", 32'(st2), 5);
        chk("en_re_squat2", 32'(squat2), 1);

        // Asynchronous reset in the first ATTACK cycle kills the pulse at once
        set_in(300, 100, 0, 0, 0);
        step(64);
        chk("rst_attack_state", 32'(st1), 3);
        chk("rst_attack_pulse", 32'(attack1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_state", 32'(st1), 0);
        chk("rst_async_outs", {right1, left1, jump1, squat1, defend1, attack1}, 0);
        step(1);
        rst_n = 1'b1;
        set_in(600, 100, 150, 1, 0);
        step(64);
        chk("rst_seed_restored", 32'(st1), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
